// File: rtl/draw_line_clip.sv
// Bresenham line rasteriser with screen clipping.
//
// Accepts a line command (two signed endpoints) over a ready/valid handshake.
// It walks the line from the endpoint with the smaller y to the other one, so y
// never decreases. Only points inside the visible screen are presented on the
// pixel ready/valid port. Off-screen points are skipped at one point per clock.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  line command handshake; x0,y0,x1,y1 sampled on transfer
//   pix_valid/pix_ready  pixel handshake towards the framebuffer; pix_x/pix_y
//   busy                 a line is in progress (FSM not idle)
//   done                 one-cycle pulse once a line has been fully walked
module draw_line_clip #(
  parameter int unsigned XY_BITW = 16,
  parameter int unsigned SCR_W   = 640,
  parameter int unsigned SCR_H   = 480
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [XY_BITW-1:0] x0,
  input  logic signed [XY_BITW-1:0] y0,
  input  logic signed [XY_BITW-1:0] x1,
  input  logic signed [XY_BITW-1:0] y1,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [XY_BITW-1:0]        pix_x,
  output logic [XY_BITW-1:0]        pix_y,
  output logic                      busy,
  output logic                      done
);

  // Two extra bits keep |dx|, -|dy| and their sum free of overflow.
  localparam int unsigned EW = XY_BITW + 2;
  localparam logic [XY_BITW-1:0] ONE = XY_BITW'(1);

  typedef enum logic [1:0] {StIdle, StInit, StDraw, StDone} state_e;

  state_e r_state, w_state_nxt;

  // Latched command endpoints
  logic signed [XY_BITW-1:0] r_px0, r_py0, r_px1, r_py1;
  // Walk state
  logic signed [XY_BITW-1:0] r_cx, r_cy, r_bx, r_by;
  logic signed [EW-1:0]      r_dx, r_dy, r_err;
  logic                      r_right;

  // Endpoint ordering and line setup
  logic                      w_swap;
  logic signed [XY_BITW-1:0] w_ax, w_ay, w_bx, w_by;
  logic signed [EW-1:0]      w_ax_e, w_ay_e, w_bx_e, w_by_e;
  logic signed [EW-1:0]      w_dx_raw, w_dx, w_dy;

  // Stepping
  logic signed [EW:0]        w_e2, w_dx_w, w_dy_w;
  logic                      w_step_x, w_step_y;
  logic signed [EW-1:0]      w_err_nxt;
  logic                      w_at_end, w_inside, w_adv;
  logic [XY_BITW-1:0]        w_cx_u, w_cy_u;

  assign w_swap = (r_py0 > r_py1);
  assign w_ax   = w_swap ? r_px1 : r_px0;
  assign w_ay   = w_swap ? r_py1 : r_py0;
  assign w_bx   = w_swap ? r_px0 : r_px1;
  assign w_by   = w_swap ? r_py0 : r_py1;

  assign w_ax_e = {{2{w_ax[XY_BITW-1]}}, w_ax};
  assign w_ay_e = {{2{w_ay[XY_BITW-1]}}, w_ay};
  assign w_bx_e = {{2{w_bx[XY_BITW-1]}}, w_bx};
  assign w_by_e = {{2{w_by[XY_BITW-1]}}, w_by};

  assign w_dx_raw = w_bx_e - w_ax_e;
  assign w_dx     = w_dx_raw[EW-1] ? -w_dx_raw : w_dx_raw;
  assign w_dy     = w_ay_e - w_by_e;  // -(yb - ya), never positive

  assign w_e2     = {r_err, 1'b0};
  assign w_dx_w   = {r_dx[EW-1], r_dx};
  assign w_dy_w   = {r_dy[EW-1], r_dy};
  assign w_step_x = (w_e2 >= w_dy_w);
  assign w_step_y = (w_e2 <= w_dx_w);

  always_comb begin
    w_err_nxt = r_err;
    if (w_step_x) w_err_nxt = w_err_nxt + r_dy;
    if (w_step_y) w_err_nxt = w_err_nxt + r_dx;
  end

  assign w_cx_u   = r_cx;
  assign w_cy_u   = r_cy;
  assign w_at_end = (r_cx == r_bx) && (r_cy == r_by);
  // Sign bit rules out negatives; the remaining magnitude compare is then unsigned.
  assign w_inside = !r_cx[XY_BITW-1] && (w_cx_u < XY_BITW'(SCR_W)) &&
                    !r_cy[XY_BITW-1] && (w_cy_u < XY_BITW'(SCR_H));
  // Off-screen points advance unconditionally; on-screen ones wait for the sink.
  assign w_adv    = (r_state == StDraw) && (!w_inside || pix_ready);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (cmd_valid) w_state_nxt = StInit;
      StInit:  w_state_nxt = StDraw;
      StDraw:  if (w_adv && w_at_end) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_px0   <= '0;
      r_py0   <= '0;
      r_px1   <= '0;
      r_py1   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_err   <= '0;
      r_right <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle && cmd_valid) begin
        r_px0 <= x0;
        r_py0 <= y0;
        r_px1 <= x1;
        r_py1 <= y1;
      end
      if (r_state == StInit) begin
        r_cx    <= w_ax;
        r_cy    <= w_ay;
        r_bx    <= w_bx;
        r_by    <= w_by;
        r_dx    <= w_dx;
        r_dy    <= w_dy;
        r_err   <= w_dx + w_dy;
        r_right <= (w_ax < w_bx);
      end
      if (w_adv && !w_at_end) begin
        if (w_step_x) r_cx <= r_right ? (r_cx + ONE) : (r_cx - ONE);
        if (w_step_y) r_cy <= r_cy + ONE;
        r_err <= w_err_nxt;
      end
    end
  end

  always_comb begin
    cmd_ready = (r_state == StIdle);
    busy      = (r_state != StIdle);
    done      = (r_state == StDone);
    pix_valid = (r_state == StDraw) && w_inside;
    pix_x     = (r_state == StDraw) ? w_cx_u : '0;
    pix_y     = (r_state == StDraw) ? w_cy_u : '0;
  end

endmodule

// File: tb/tb_draw_line_clip.sv
module tb_draw_line_clip;

  localparam int SW = 640;
  localparam int SH = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic pix_ready = 1'b0;
  logic signed [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic cmd_ready, pix_valid, busy, done;
  logic [15:0] pix_x, pix_y;

  draw_line_clip #(.XY_BITW(16), .SCR_W(SW), .SCR_H(SH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pix_t;

  pix_t exp_q[$];
  pix_t act_q[$];
  int   act_c[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt, done_c, gap_cnt;
  pix_t e, a;

  task automatic push_exp(input int px, input int py);
    exp_q.push_back({16'(px), 16'(py)});
  endtask

  // Reference rasteriser: pushes the visible points, returns total point count.
  task automatic model_line(input int ax, input int ay, input int bx, input int by,
                            output int npts);
    int t, dx, dy, err, e2, sx, cx, cy;
    if (ay > by) begin
      t = ax; ax = bx; bx = t;
      t = ay; ay = by; by = t;
    end
    dx  = (bx > ax) ? bx - ax : ax - bx;
    dy  = ay - by;
    err = dx + dy;
    sx  = (ax < bx) ? 1 : -1;
    cx  = ax;
    cy  = ay;
    npts = 0;
    forever begin
      npts++;
      if (cx >= 0 && cx < SW && cy >= 0 && cy < SH) push_exp(cx, cy);
      if (cx == bx && cy == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += 1; end
    end
  endtask

  task automatic send_cmd(input int ax, input int ay, input int bx, input int by);
    @(negedge clk);
    x0 = 16'(ax); y0 = 16'(ay); x1 = 16'(bx); y1 = 16'(by);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Records handshaken pixels with their cycle index (1 = INIT cycle after the
  // command handshake); stops on done or when the budget runs out.
  task automatic collect(input int budget);
    act_q.delete();
    act_c.delete();
    done_cnt = 0;
    done_c   = -1;
    gap_cnt  = 0;
    pix_ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        act_q.push_back({pix_x, pix_y});
        act_c.push_back(c);
      end
      if (busy && !pix_valid && !done) gap_cnt++;
      if (done) begin
        done_cnt++;
        done_c = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cmd_ready, pix_valid, busy, done} !== 4'b1000) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b want 1000", {cmd_ready, pix_valid, busy, done});
    end
    n_checks++;
    if (pix_x !== 16'd0 || pix_y !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_pix got (%0d,%0d) want (0,0)", pix_x, pix_y);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_horizontal();
    send_cmd(0, 0, 3, 0);
    for (int i = 0; i < 4; i++) push_exp(i, 0);
    collect(50);
    n_checks++;
    if (act_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL horiz_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL horiz_pix got (%0d,%0d) want (%0d,%0d)", a.x, a.y, e.x, e.y);
      end
    end
    exp_q.delete();
    n_checks++;
    if (act_c.size() != 4 || act_c[0] != 2 || act_c[3] != 5) begin
      n_errors++;
      $display("FAIL horiz_timing got first %0d n %0d want first 2 n 4",
               (act_c.size() > 0) ? act_c[0] : -1, act_c.size());
    end
    n_checks++;
    if (done_c != 6) begin
      n_errors++;
      $display("FAIL horiz_done_cycle got %0d want 6", done_c);
    end
  endtask

  task automatic test_steep_swap();
    send_cmd(2, 5, 0, 0);
    push_exp(0, 0); push_exp(0, 1); push_exp(1, 2);
    push_exp(1, 3); push_exp(2, 4); push_exp(2, 5);
    collect(50);
    n_checks++;
    if (act_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL steep_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL steep_pix got (%0d,%0d) want (%0d,%0d)", a.x, a.y, e.x, e.y);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_left_clip();
    send_cmd(-2, 1, 2, 1);
    push_exp(0, 1); push_exp(1, 1); push_exp(2, 1);
    collect(50);
    n_checks++;
    if (act_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL lclip_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL lclip_pix got (%0d,%0d) want (%0d,%0d)", a.x, a.y, e.x, e.y);
      end
    end
    exp_q.delete();
    // INIT cycle plus two skipped points
    n_checks++;
    if (gap_cnt != 3 || done_c != 7) begin
      n_errors++;
      $display("FAIL lclip_skip got gaps %0d done %0d want gaps 3 done 7", gap_cnt, done_c);
    end
  endtask

  task automatic test_offscreen();
    send_cmd(700, 10, 800, 20);
    collect(300);
    n_checks++;
    if (act_q.size() != 0 || done_cnt != 1) begin
      n_errors++;
      $display("FAIL offscr got pixels %0d dones %0d want 0 1", act_q.size(), done_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL offscr_after got done %b ready %b busy %b want 0 1 0",
               done, cmd_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    bit   prev_stall = 1'b0;
    bit   seen_done = 1'b0;
    logic [15:0] px = '0, py = '0;
    send_cmd(0, 0, 3, 3);
    for (int i = 0; i < 4; i++) push_exp(i, i);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      pix_ready = ((c % 4) == 1) || ((c % 4) == 0);
      if (prev_stall) begin
        n_checks++;
        if (!pix_valid || pix_x !== px || pix_y !== py) begin
          n_errors++;
          $display("FAIL stall_hold got v%b (%0d,%0d) want v1 (%0d,%0d)",
                   pix_valid, pix_x, pix_y, px, py);
        end
      end
      if (pix_valid && pix_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stall_extra got (%0d,%0d) want none", pix_x, pix_y);
        end else begin
          e = exp_q.pop_front();
          if ({pix_x, pix_y} !== e) begin
            n_errors++;
            $display("FAIL stall_pix got (%0d,%0d) want (%0d,%0d)", pix_x, pix_y, e.x, e.y);
          end
        end
      end
      prev_stall = pix_valid && !pix_ready;
      px = pix_x;
      py = pix_y;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen_done || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stall_end got done %b left %0d want done 1 left 0", seen_done, exp_q.size());
    end
    exp_q.delete();
    pix_ready = 1'b1;
  endtask

  task automatic test_reset_midline();
    int hs = 0;
    int bad = 0;
    send_cmd(0, 0, 10, 0);
    pix_ready = 1'b1;
    for (int c = 0; c < 30 && hs < 2; c++) begin
      @(negedge clk);
      if (pix_valid && pix_ready) hs++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, pix_valid, busy, done} !== 4'b1000 || pix_x !== 16'd0 ||
        pix_y !== 16'd0 || hs != 2) begin
      n_errors++;
      $display("FAIL midrst_out got r%b v%b b%b d%b (%0d,%0d) hs %0d want r1 v0 b0 d0 (0,0) 2",
               cmd_ready, pix_valid, busy, done, pix_x, pix_y, hs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pix_valid || done || busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL midrst_quiet got %0d active cycles want 0", bad);
    end
    send_cmd(1, 2, 3, 2);
    push_exp(1, 2); push_exp(2, 2); push_exp(3, 2);
    collect(50);
    n_checks++;
    if (act_q.size() != exp_q.size() || done_c != 5) begin
      n_errors++;
      $display("FAIL midrst_next got %0d pixels done %0d want %0d pixels done 5",
               act_q.size(), done_c, exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL midrst_pix got (%0d,%0d) want (%0d,%0d)", a.x, a.y, e.x, e.y);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_single_point();
    send_cmd(5, 5, 5, 5);
    push_exp(5, 5);
    collect(20);
    n_checks++;
    if (act_q.size() != 1 || done_c != 3) begin
      n_errors++;
      $display("FAIL single_count got %0d pixels done %0d want 1 done 3", act_q.size(), done_c);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL single_pix got (%0d,%0d) want (%0d,%0d)", a.x, a.y, e.x, e.y);
      end
    end
    exp_q.delete();
  endtask

  // Second command held valid throughout the first line: it must wait, and the
  // input changes after the first handshake must not disturb the first line.
  task automatic test_back_to_back();
    @(negedge clk);
    x0 = 16'sd4; y0 = 16'sd4; x1 = 16'sd6; y1 = 16'sd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 x0 = 16'sd10; y0 = 16'sd20; x1 = 16'sd10; y1 = 16'sd22;
    push_exp(4, 4); push_exp(5, 4); push_exp(6, 4);
    collect(50);
    @(posedge clk);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    push_exp(10, 20); push_exp(10, 21); push_exp(10, 22);
    while (exp_q.size() > 3 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL b2b_first got (%0d,%0d) want (%0d,%0d)", a.x, a.y, e.x, e.y);
      end
    end
    n_checks++;
    if (exp_q.size() != 3 || act_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_first_count got left exp %0d act %0d want 3 0",
               exp_q.size(), act_q.size());
    end
    collect(50);
    n_checks++;
    if (act_q.size() != 3 || done_c != 5) begin
      n_errors++;
      $display("FAIL b2b_second got %0d pixels done %0d want 3 done 5", act_q.size(), done_c);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL b2b_pix got (%0d,%0d) want (%0d,%0d)", a.x, a.y, e.x, e.y);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int ax, ay, bx, by, npts;
    for (int n = 0; n < 7; n++) begin
      if (n == 0) begin
        ax = -30; ay = -10; bx = 700; by = 490;
      end else begin
        ax = int'($urandom_range(0, 100)) - 20;
        ay = int'($urandom_range(0, 100)) - 20;
        bx = int'($urandom_range(560, 680));
        by = int'($urandom_range(0, 100)) - 20;
        if (n % 2 == 1) begin
          bx = ax + int'($urandom_range(0, 30)) - 15;
          by = int'($urandom_range(400, 520));
        end
      end
      send_cmd(ax, ay, bx, by);
      model_line(ax, ay, bx, by, npts);
      collect(3000);
      n_checks++;
      if (act_q.size() != exp_q.size() || done_c != npts + 2) begin
        n_errors++;
        $display("FAIL rand%0d_count got %0d pixels done %0d want %0d pixels done %0d",
                 n, act_q.size(), done_c, exp_q.size(), npts + 2);
      end
      while (exp_q.size() > 0 && act_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL rand%0d_pix got (%0d,%0d) want (%0d,%0d)", n, a.x, a.y, e.x, e.y);
        end
      end
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_steep_swap();
    test_left_clip();
    test_offscreen();
    test_backpressure();
    test_reset_midline();
    test_single_point();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
